// File: rtl/mem_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_pkg : shared bus layouts, size codes and FSM states          |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package mem_pkg;

    localparam int EX_BUS_W = 139;
    localparam int WB_BUS_W = 70;

    // LSB offsets of the execute->memory payload fields
    localparam int EXB_ALU_LSB   = 0;
    localparam int EXB_SD_LSB    = 32;
    localparam int EXB_WADDR_LSB = 64;
    localparam int EXB_LDU       = 69;
    localparam int EXB_SIZE_LSB  = 70;
    localparam int EXB_GRWE      = 72;
    localparam int EXB_RFM       = 73;
    localparam int EXB_MEMWE     = 74;
    localparam int EXB_IR_LSB    = 75;
    localparam int EXB_PC_LSB    = 107;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_if : execute, data-SRAM and write-back signals of mem_stage  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface mem_if #(
    parameter int DATA_W = 32
);
    import mem_pkg::*;

    logic                ex_valid;
    logic [EX_BUS_W-1:0] ex_bus;
    logic                mem_allowin;

    logic                data_req;
    logic                data_wr;
    logic [1:0]          data_size;
    logic [3:0]          data_wstrb;
    logic [DATA_W-1:0]   data_addr;
    logic [DATA_W-1:0]   data_wdata;
    logic                data_addr_ok;
    logic                data_data_ok;
    logic [DATA_W-1:0]   data_rdata;

    logic                wb_allowin;
    logic                mem_to_wb_valid;
    logic [WB_BUS_W-1:0] mem_to_wb_bus;

    modport slave (
        input  ex_valid, ex_bus, data_addr_ok, data_data_ok, data_rdata, wb_allowin,
        output mem_allowin, data_req, data_wr, data_size, data_wstrb, data_addr,
               data_wdata, mem_to_wb_valid, mem_to_wb_bus
    );

    modport master (
        output ex_valid, ex_bus, data_addr_ok, data_data_ok, data_rdata, wb_allowin,
        input  mem_allowin, data_req, data_wr, data_size, data_wstrb, data_addr,
               data_wdata, mem_to_wb_valid, mem_to_wb_bus
    );

endinterface
`default_nettype wire

// File: rtl/mem_lsu_align.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_lsu_align : store lane replication/strobes, load extraction  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module mem_lsu_align
    import mem_pkg::*;
(
    input  wire logic [1:0]  i_size,
    input  wire logic [1:0]  i_addr_lo,
    input  wire logic        i_load_unsigned,
    input  wire logic [31:0] i_store_data,
    input  wire logic [31:0] i_rdata,
    output logic      [3:0]  o_wstrb,
    output logic      [31:0] o_wdata,
    output logic      [31:0] o_load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        unique case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    // An undefined size code behaves as a word access
    always_comb begin
        o_wstrb     = 4'b1111;
        o_wdata     = i_store_data;
        o_load_data = i_rdata;
        unique case (i_size)
            SZ_B: begin
                o_wstrb     = 4'b0001 << i_addr_lo;
                o_wdata     = {4{i_store_data[7:0]}};
                o_load_data = {{24{~i_load_unsigned & w_byte[7]}}, w_byte};
            end
            SZ_H: begin
                o_wstrb     = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata     = {2{i_store_data[15:0]}};
                o_load_data = {{16{~i_load_unsigned & w_half[15]}}, w_half};
            end
            default: begin
                o_wstrb     = 4'b1111;
                o_wdata     = i_store_data;
                o_load_data = i_rdata;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_stage : LoongArch memory-access stage (data-SRAM + result)   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module mem_stage
    import mem_pkg::*;
#(
    parameter int DATA_W = 32
)(
    input  wire logic clk,
    input  wire logic rst,
    mem_if.slave      bus
);

    state_t              r_state_q,  w_state_d;
    logic [DATA_W-1:0]   r_pc_q,     w_pc_d;
    logic                r_mem_we_q, w_mem_we_d;
    logic                r_rfm_q,    w_rfm_d;
    logic                r_gr_we_q,  w_gr_we_d;
    logic [1:0]          r_size_q,   w_size_d;
    logic                r_ldu_q,    w_ldu_d;
    logic [4:0]          r_waddr_q,  w_waddr_d;
    logic [DATA_W-1:0]   r_sd_q,     w_sd_d;
    logic [DATA_W-1:0]   r_alu_q,    w_alu_d;
    logic [DATA_W-1:0]   r_result_q, w_result_d;

    logic                w_allowin;
    logic                w_accept;
    logic [3:0]          w_wstrb;
    logic [DATA_W-1:0]   w_wdata;
    logic [DATA_W-1:0]   w_load_data;
    logic                w_unused_ir;

    assign w_unused_ir = ^bus.ex_bus[EXB_IR_LSB +: 32];

    assign w_allowin = (r_state_q == IDLE) | ((r_state_q == DONE) & bus.wb_allowin);
    assign w_accept  = bus.ex_valid & w_allowin;

    always_comb begin
        w_state_d  = r_state_q;
        w_pc_d     = r_pc_q;
        w_mem_we_d = r_mem_we_q;
        w_rfm_d    = r_rfm_q;
        w_gr_we_d  = r_gr_we_q;
        w_size_d   = r_size_q;
        w_ldu_d    = r_ldu_q;
        w_waddr_d  = r_waddr_q;
        w_sd_d     = r_sd_q;
        w_alu_d    = r_alu_q;
        w_result_d = r_result_q;
        unique case (r_state_q)
            IDLE, DONE: begin
                if (w_accept) begin
                    w_pc_d     = bus.ex_bus[EXB_PC_LSB +: DATA_W];
                    w_mem_we_d = bus.ex_bus[EXB_MEMWE];
                    w_rfm_d    = bus.ex_bus[EXB_RFM];
                    w_gr_we_d  = bus.ex_bus[EXB_GRWE];
                    w_size_d   = bus.ex_bus[EXB_SIZE_LSB +: 2];
                    w_ldu_d    = bus.ex_bus[EXB_LDU];
                    w_waddr_d  = bus.ex_bus[EXB_WADDR_LSB +: 5];
                    w_sd_d     = bus.ex_bus[EXB_SD_LSB +: DATA_W];
                    w_alu_d    = bus.ex_bus[EXB_ALU_LSB +: DATA_W];
                    w_result_d = bus.ex_bus[EXB_ALU_LSB +: DATA_W];
                    w_state_d  = (bus.ex_bus[EXB_MEMWE] | bus.ex_bus[EXB_RFM]) ? REQ : DONE;
                end else if ((r_state_q == DONE) && bus.wb_allowin) begin
                    w_state_d = IDLE;
                end
            end
            REQ: begin
                if (bus.data_addr_ok) begin
                    if (bus.data_data_ok) begin
                        w_state_d = DONE;
                        if (r_rfm_q) w_result_d = w_load_data;
                    end else begin
                        w_state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (bus.data_data_ok) begin
                    w_state_d = DONE;
                    if (r_rfm_q) w_result_d = w_load_data;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= IDLE;
            r_pc_q     <= '0;
            r_mem_we_q <= 1'b0;
            r_rfm_q    <= 1'b0;
            r_gr_we_q  <= 1'b0;
            r_size_q   <= 2'b00;
            r_ldu_q    <= 1'b0;
            r_waddr_q  <= 5'd0;
            r_sd_q     <= '0;
            r_alu_q    <= '0;
            r_result_q <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_pc_q     <= w_pc_d;
            r_mem_we_q <= w_mem_we_d;
            r_rfm_q    <= w_rfm_d;
            r_gr_we_q  <= w_gr_we_d;
            r_size_q   <= w_size_d;
            r_ldu_q    <= w_ldu_d;
            r_waddr_q  <= w_waddr_d;
            r_sd_q     <= w_sd_d;
            r_alu_q    <= w_alu_d;
            r_result_q <= w_result_d;
        end
    end

    mem_lsu_align u_align (
        .i_size          (r_size_q),
        .i_addr_lo       (r_alu_q[1:0]),
        .i_load_unsigned (r_ldu_q),
        .i_store_data    (r_sd_q),
        .i_rdata         (bus.data_rdata),
        .o_wstrb         (w_wstrb),
        .o_wdata         (w_wdata),
        .o_load_data     (w_load_data)
    );

    // Every request-side output comes from the stage register, so it holds until addr_ok
    assign bus.mem_allowin     = w_allowin;
    assign bus.data_req        = (r_state_q == REQ);
    assign bus.data_wr         = r_mem_we_q;
    assign bus.data_size       = r_size_q;
    assign bus.data_addr       = r_alu_q;
    assign bus.data_wstrb      = w_wstrb & {4{r_mem_we_q}};
    assign bus.data_wdata      = w_wdata;
    assign bus.mem_to_wb_valid = (r_state_q == DONE);
    assign bus.mem_to_wb_bus   = {r_pc_q, r_gr_we_q & ~r_mem_we_q, r_waddr_q, r_result_q};

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mem_stage : directed + randomized checks of mem_stage         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_mem_stage;
    import mem_pkg::*;

    localparam int N_RAND   = 300;
    localparam int MAX_CYC  = 20000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_if #(.DATA_W(32)) bus_if ();

    mem_stage #(.DATA_W(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
        logic        we;
        logic        rfm;
        logic        gwe;
        logic [1:0]  sz;
        logic        uns;
        logic [4:0]  wa;
        logic [31:0] sd;
        logic [31:0] alu;
    } insn_t;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic insn_t mk(input logic [31:0] pc, input logic we, input logic rfm,
                                 input logic gwe, input logic [1:0] sz, input logic uns,
                                 input logic [4:0] wa, input logic [31:0] sd, input logic [31:0] alu);
        insn_t i;
        i.pc = pc; i.ir = $urandom; i.we = we; i.rfm = rfm; i.gwe = gwe;
        i.sz = sz; i.uns = uns; i.wa = wa; i.sd = sd; i.alu = alu;
        return i;
    endfunction

    function automatic logic [138:0] pack(input insn_t i);
        return {i.pc, i.ir, i.we, i.rfm, i.gwe, i.sz, i.uns, i.wa, i.sd, i.alu};
    endfunction

    // Reference model: plain shift/mask/multiply arithmetic on the access rules
    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [31:0] rd,
                                             input logic [1:0] sz, input logic uns);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (rd >> (8 * (addr % 4))) & 32'hFF;
            if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (rd >> (8 * (addr & 32'd2))) & 32'hFFFF;
            if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    function automatic logic [3:0] ref_strb(input logic [31:0] addr, input logic [1:0] sz);
        logic [31:0] s;
        if (sz == 2'd0)      s = 32'd1 << (addr % 4);
        else if (sz == 2'd1) s = 32'd3 << (addr & 32'd2);
        else                 s = 32'd15;
        return s[3:0];
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [31:0] sd, input logic [1:0] sz);
        if (sz == 2'd0)      return (sd & 32'hFF) * 32'h0101_0101;
        else if (sz == 2'd1) return (sd & 32'hFFFF) * 32'h0001_0001;
        else                 return sd;
    endfunction

    function automatic logic [69:0] ref_wb(input insn_t i, input logic [31:0] res);
        return {i.pc, i.gwe & ~i.we, i.wa, res};
    endfunction

    function automatic insn_t rand_insn();
        int          kind;
        logic [1:0]  sz;
        logic [31:0] a;
        kind = $urandom_range(0, 2);
        sz   = 2'($urandom_range(0, 2));
        a    = $urandom;
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
        return mk($urandom, kind == 2, kind == 1, 1'($urandom), sz, 1'($urandom),
                  5'($urandom), $urandom, a);
    endfunction

    task automatic load_test(input string tag, input logic [31:0] addr, input logic [31:0] rd,
                             input logic [1:0] sz, input logic uns, input logic [31:0] exp);
        insn_t a;
        a = mk(32'h0000_1C00, 1'b0, 1'b1, 1'b1, sz, uns, 5'd7, $urandom, addr);
        bus_if.ex_valid = 1'b1;
        bus_if.ex_bus   = pack(a);
        @(negedge clk);
        bus_if.ex_valid = 1'b0;
        check({tag, "_req"},  bus_if.data_req, 1'b1);
        check({tag, "_addr"}, bus_if.data_addr, addr);
        check({tag, "_wr"},   bus_if.data_wr, 1'b0);
        check({tag, "_size"}, bus_if.data_size, sz);
        bus_if.data_addr_ok = 1'b1;
        @(negedge clk);
        check({tag, "_req_drop"}, bus_if.data_req, 1'b0);
        check({tag, "_early"},    bus_if.mem_to_wb_valid, 1'b0);
        bus_if.data_addr_ok = 1'b0;
        bus_if.data_data_ok = 1'b1;
        bus_if.data_rdata   = rd;
        @(negedge clk);
        bus_if.data_data_ok = 1'b0;
        check({tag, "_valid"}, bus_if.mem_to_wb_valid, 1'b1);
        check({tag, "_res"},   bus_if.mem_to_wb_bus[31:0], exp);
        check({tag, "_bus"},   bus_if.mem_to_wb_bus, ref_wb(a, exp));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        insn_t       a;
        insn_t       b;
        insn_t       pend;
        insn_t       cur;
        insn_t       mq[$];
        logic [69:0] wq[$];
        bit          have_pend;
        int          sent;
        int          phase;
        int          cyc;

        rst = 1'b1;
        bus_if.ex_valid     = 1'b0;
        bus_if.ex_bus       = '0;
        bus_if.data_addr_ok = 1'b0;
        bus_if.data_data_ok = 1'b0;
        bus_if.data_rdata   = '0;
        bus_if.wb_allowin   = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_allowin", bus_if.mem_allowin, 1'b1);
        check("rst_req",     bus_if.data_req, 1'b0);
        check("rst_valid",   bus_if.mem_to_wb_valid, 1'b0);
        check("rst_bus",     bus_if.mem_to_wb_bus, 70'd0);
        rst = 1'b0;

        // back-to-back ALU results
        for (int k = 0; k < 3; k++) begin
            a = mk(32'h100 + 32'(4 * k), 1'b0, 1'b0, 1'b1, SZ_W, 1'b0, 5'(k + 1),
                   $urandom, 32'h11 * 32'(k + 1));
            bus_if.ex_valid = 1'b1;
            bus_if.ex_bus   = pack(a);
            @(negedge clk);
            check("alu_valid", bus_if.mem_to_wb_valid, 1'b1);
            check("alu_res",   bus_if.mem_to_wb_bus[31:0], 32'h11 * 32'(k + 1));
            check("alu_bus",   bus_if.mem_to_wb_bus, ref_wb(a, a.alu));
        end
        bus_if.ex_valid = 1'b0;
        @(negedge clk);
        check("alu_drain", bus_if.mem_to_wb_valid, 1'b0);

        load_test("ld_b",  32'h0000_1003, 32'h80FF_FF12, SZ_B, 1'b0, 32'hFFFF_FF80);
        load_test("ld_bu", 32'h0000_1003, 32'h80FF_FF12, SZ_B, 1'b1, 32'h0000_0080);
        load_test("ld_h",  32'h0000_1002, 32'h9234_5678, SZ_H, 1'b0, 32'hFFFF_9234);

        // st.h with addr_ok held off for 3 cycles
        a = mk(32'h300, 1'b1, 1'b0, 1'b1, SZ_H, 1'b0, 5'd3, 32'h0000_ABCD, 32'h0000_2002);
        bus_if.ex_valid = 1'b1;
        bus_if.ex_bus   = pack(a);
        @(negedge clk);
        bus_if.ex_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check("st_req",   bus_if.data_req, 1'b1);
            check("st_wr",    bus_if.data_wr, 1'b1);
            check("st_strb",  bus_if.data_wstrb, 4'b1100);
            check("st_wdata", bus_if.data_wdata, 32'hABCD_ABCD);
            check("st_addr",  bus_if.data_addr, 32'h0000_2002);
            if (c == 3) bus_if.data_addr_ok = 1'b1;
            @(negedge clk);
        end
        bus_if.data_addr_ok = 1'b0;
        check("st_wait_req", bus_if.data_req, 1'b0);
        bus_if.data_data_ok = 1'b1;
        @(negedge clk);
        bus_if.data_data_ok = 1'b0;
        check("st_valid", bus_if.mem_to_wb_valid, 1'b1);
        check("st_grwe",  bus_if.mem_to_wb_bus[37], 1'b0);
        check("st_res",   bus_if.mem_to_wb_bus[31:0], 32'h0000_2002);

        // addr_ok and data_ok together: result two cycles after acceptance
        a = mk(32'h400, 1'b0, 1'b1, 1'b1, SZ_W, 1'b0, 5'd9, $urandom, 32'h0000_0040);
        bus_if.ex_valid = 1'b1;
        bus_if.ex_bus   = pack(a);
        @(negedge clk);
        bus_if.ex_valid = 1'b0;
        check("fast_req", bus_if.data_req, 1'b1);
        bus_if.data_addr_ok = 1'b1;
        bus_if.data_data_ok = 1'b1;
        bus_if.data_rdata   = 32'h1234_5678;
        @(negedge clk);
        bus_if.data_addr_ok = 1'b0;
        bus_if.data_data_ok = 1'b0;
        check("fast_valid", bus_if.mem_to_wb_valid, 1'b1);
        check("fast_res",   bus_if.mem_to_wb_bus[31:0], 32'h1234_5678);
        @(negedge clk);

        // write-back stall, then drain and accept on the same edge
        bus_if.wb_allowin = 1'b0;
        a = mk(32'h500, 1'b0, 1'b0, 1'b1, SZ_W, 1'b0, 5'd5, $urandom, 32'h55);
        b = mk(32'h504, 1'b0, 1'b0, 1'b1, SZ_W, 1'b0, 5'd6, $urandom, 32'h66);
        bus_if.ex_valid = 1'b1;
        bus_if.ex_bus   = pack(a);
        @(negedge clk);
        bus_if.ex_bus   = pack(b);
        for (int c = 0; c < 4; c++) begin
            #1;
            check("stall_allowin", bus_if.mem_allowin, 1'b0);
            check("stall_valid",   bus_if.mem_to_wb_valid, 1'b1);
            check("stall_bus",     bus_if.mem_to_wb_bus, ref_wb(a, a.alu));
            @(negedge clk);
        end
        bus_if.wb_allowin = 1'b1;
        #1;
        check("resume_allowin", bus_if.mem_allowin, 1'b1);
        @(negedge clk);
        bus_if.ex_valid = 1'b0;
        check("resume_valid", bus_if.mem_to_wb_valid, 1'b1);
        check("resume_bus",   bus_if.mem_to_wb_bus, ref_wb(b, b.alu));
        @(negedge clk);
        check("resume_drain", bus_if.mem_to_wb_valid, 1'b0);

        // reset while waiting for data, then a stray data_ok
        a = mk(32'h600, 1'b0, 1'b1, 1'b1, SZ_W, 1'b0, 5'd4, $urandom, 32'h80);
        bus_if.ex_valid = 1'b1;
        bus_if.ex_bus   = pack(a);
        @(negedge clk);
        bus_if.ex_valid     = 1'b0;
        bus_if.data_addr_ok = 1'b1;
        @(negedge clk);
        bus_if.data_addr_ok = 1'b0;
        check("abort_wait_req", bus_if.data_req, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus_if.data_data_ok = 1'b1;
        bus_if.data_rdata   = 32'hDEAD_BEEF;
        @(negedge clk);
        bus_if.data_data_ok = 1'b0;
        check("abort_valid",   bus_if.mem_to_wb_valid, 1'b0);
        check("abort_req",     bus_if.data_req, 1'b0);
        check("abort_bus",     bus_if.mem_to_wb_bus, 70'd0);
        check("abort_allowin", bus_if.mem_allowin, 1'b1);
        @(negedge clk);
        check("abort_valid2",  bus_if.mem_to_wb_valid, 1'b0);

        // randomized traffic against the transaction-level model
        have_pend = 1'b0;
        sent  = 0;
        phase = 0;
        cyc   = 0;
        while ((sent < N_RAND || have_pend || mq.size() > 0 || wq.size() > 0) && cyc < MAX_CYC) begin
            if (!have_pend && sent < N_RAND && $urandom_range(0, 3) != 0) begin
                pend = rand_insn();
                have_pend = 1'b1;
            end
            bus_if.ex_valid = have_pend;
            if (have_pend) bus_if.ex_bus = pack(pend);
            bus_if.wb_allowin   = ($urandom_range(0, 3) != 0);
            bus_if.data_addr_ok = bus_if.data_req && ($urandom_range(0, 2) == 0);
            if (phase == 1)
                bus_if.data_data_ok = ($urandom_range(0, 2) == 0);
            else if (bus_if.data_addr_ok)
                bus_if.data_data_ok = ($urandom_range(0, 3) == 0);
            else if (mq.size() == 0 && !bus_if.data_req)
                bus_if.data_data_ok = ($urandom_range(0, 7) == 0);
            else
                bus_if.data_data_ok = 1'b0;
            bus_if.data_rdata = $urandom;
            #1;
            if (bus_if.wb_allowin && bus_if.mem_to_wb_valid) begin
                if (wq.size() == 0) check("rnd_extra_valid", bus_if.mem_to_wb_valid, 1'b0);
                else                check("rnd_wb", bus_if.mem_to_wb_bus, wq.pop_front());
            end
            if (bus_if.data_req && bus_if.data_addr_ok) begin
                if (mq.size() == 0) begin
                    check("rnd_stray_req", bus_if.data_req, 1'b0);
                end else begin
                    cur = mq[0];
                    check("rnd_addr", bus_if.data_addr, cur.alu);
                    check("rnd_wr",   bus_if.data_wr, cur.we);
                    check("rnd_size", bus_if.data_size, cur.sz);
                    if (cur.we) begin
                        check("rnd_strb",  bus_if.data_wstrb, ref_strb(cur.alu, cur.sz));
                        check("rnd_wdata", bus_if.data_wdata, ref_wdata(cur.sd, cur.sz));
                    end
                    phase = 1;
                end
            end
            if (phase == 1 && bus_if.data_data_ok && mq.size() > 0) begin
                cur = mq.pop_front();
                wq.push_back(ref_wb(cur, cur.rfm ?
                    ref_load(cur.alu, bus_if.data_rdata, cur.sz, cur.uns) : cur.alu));
                phase = 0;
            end
            if (bus_if.ex_valid && bus_if.mem_allowin) begin
                if (pend.we || pend.rfm) mq.push_back(pend);
                else                     wq.push_back(ref_wb(pend, pend.alu));
                have_pend = 1'b0;
                sent++;
            end
            @(negedge clk);
            cyc++;
        end
        check("rnd_complete", {63'd0, 7'(wq.size() + mq.size() + (N_RAND - sent))}, 70'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
